// File: rtl/chan_mux_pkg.sv
// Shared definitions for the round-robin channel multiplexer: selection modes,
// grant counter width and the output-register FSM encoding.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int CNT_W = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/chan_mux_rr_pick.sv
// Pointer-rotated priority picker: first asserted req at or after ptr, wrapping.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick #(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            // ptr is always below N_CH, so one subtraction is enough to wrap
            idx = int'(ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered mux, fixed-select or round-robin, 1-cycle latency, 1 word/cycle.
// in_ready only for the granted channel while the output register can load; CHAN_MUX_CNT_EN adds grant counters.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter  int N_CH  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch,
    output logic [N_CH*CNT_W-1:0] grant_cnt
);

    localparam logic [SEL_W:0]   N_CH_L = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST   = SEL_W'(N_CH - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx, g_idx;
    logic             rr_any, fix_any, g_any;
    logic             load_en, xfer;

    rr_pick #(.N_CH(N_CH)) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    // Out-of-range select values (non power-of-2 N_CH) must never grant.
    assign fix_any = ({1'b0, sel} < N_CH_L) && in_valid[sel];
    assign g_any   = (mode == MODE_RR) ? rr_any : fix_any;
    assign g_idx   = (mode == MODE_RR) ? rr_idx : sel;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        xfer      = 1'b0;
        case (state)
            ST_EMPTY: load_en = 1'b1;
            ST_FULL:  load_en = out_ready;
            default:  load_en = 1'b0;
        endcase
        xfer = rst_n && load_en && g_any;
        if (xfer)
            state_nxt = ST_FULL;
        else if (state == ST_FULL && out_ready)
            state_nxt = ST_EMPTY;
    end

    always_comb begin
        in_ready = '0;
        for (int k = 0; k < N_CH; k++)
            in_ready[k] = xfer && (g_idx == SEL_W'(k));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            ptr      <= '0;
        end else if (xfer) begin
            out_data <= in_data[g_idx*WIDTH +: WIDTH];
            out_ch   <= g_idx;
            ptr      <= (g_idx == LAST) ? '0 : g_idx + 1'b1;
        end
    end

    assign out_valid = (state == ST_FULL);

`ifdef CHAN_MUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_CH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
        end else if (xfer && cnt_q[g_idx] != '1) begin
            cnt_q[g_idx] <= cnt_q[g_idx] + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        assign grant_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed self-checking bench for chan_mux_rr with N_CH=4, WIDTH=8.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_chan_mux_rr;
    import chan_mux_pkg::*;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  mode;
    logic [SEL_W-1:0]      sel;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [SEL_W-1:0]      out_ch;
    logic [N_CH*CNT_W-1:0] grant_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chan_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .grant_cnt (grant_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        in_data = {8'h3C, 8'hA5, 8'h5A, 8'h11};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = MODE_RR; sel = '0; in_valid = 4'b1111; out_ready = 1'b1;
        set_default_data();
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        checks++; if (grant_cnt !== '0) begin failures++; $display("FAIL reset_grant_cnt got=%h exp=0", grant_cnt); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%b exp=0001", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
            failures++; $display("FAIL reset_first_word got=%b/%0d/%h exp=1/0/11", out_valid, out_ch, out_data); end
    endtask

    task automatic test_fixed();
        mode = MODE_FIXED; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_in_ready got=%b exp=0100", in_ready); end
        step();
        checks++; if (out_data !== 8'hA5 || out_ch !== 2'd2) begin
            failures++; $display("FAIL fixed_word got=%h/%0d exp=a5/2", out_data, out_ch); end
        in_data[16 +: 8] = 8'h5C;
        step();
        checks++; if (out_data !== 8'h5C || out_valid !== 1'b1) begin
            failures++; $display("FAIL fixed_stream got=%h/%b exp=5c/1", out_data, out_valid); end
        sel = 2'd1;
        #1;
        checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL fixed_sel_change got=%b exp=0010", in_ready); end
        step();
        checks++; if (out_data !== 8'h5A || out_ch !== 2'd1) begin
            failures++; $display("FAIL fixed_sel_word got=%h/%0d exp=5a/1", out_data, out_ch); end
        set_default_data();
    endtask

    task automatic test_round_robin();
        logic [SEL_W-1:0] exp_seq [6];
        exp_seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        do_reset();
        mode = MODE_RR; in_valid = 4'b1011; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << exp_seq[i])) begin
                failures++; $display("FAIL rr_in_ready[%0d] got=%b exp_ch=%0d", i, in_ready, exp_seq[i]); end
            step();
            checks++; if (out_ch !== exp_seq[i] || out_data !== in_data[exp_seq[i]*8 +: 8]) begin
                failures++; $display("FAIL rr_out[%0d] got=%0d/%h exp_ch=%0d", i, out_ch, out_data, exp_seq[i]); end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data[24 +: 8] = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h3C || in_ready !== 4'b0000) begin
                failures++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h/%b exp=1/3/3c/0000", i, out_valid, out_ch, out_data, in_ready); end
        end
        set_default_data();
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h11) begin
            failures++; $display("FAIL bp_release_word got=%b/%0d/%h exp=1/0/11", out_valid, out_ch, out_data); end
    endtask

    task automatic test_drain();
        in_valid = 4'b0000; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL drain_in_ready got=%b exp=0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
        mode = MODE_FIXED; sel = 2'd3; in_valid = 4'b0111;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_nogrant_ready got=%b exp=0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fixed_nogrant_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        mode = MODE_RR; in_valid = 4'b1111; out_ready = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_load got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL mid_rst_discard got=%b/%h exp=0/00", out_valid, out_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_counters();
        logic [N_CH*CNT_W-1:0] exp_cnt;
        do_reset();
        mode = MODE_RR; in_valid = 4'b0011; out_ready = 1'b1;
        repeat (10) step();
        in_valid = 4'b0000;
        step();
`ifdef CHAN_MUX_CNT_EN
        exp_cnt = {16'd0, 16'd0, 16'd5, 16'd5};
`else
        exp_cnt = '0;
`endif
        checks++; if (grant_cnt !== exp_cnt) begin failures++; $display("FAIL grant_cnt got=%h exp=%h", grant_cnt, exp_cnt); end
        checks++; if (out_ch !== 2'd1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL cnt_last got=%0d/%b exp=1/0", out_ch, out_valid); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_counters();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
